// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared widths, FSM state type and captured-request record
// Purpose: common definitions imported by the APB master arbiter files.
// Macros: APB_ADDR_WIDTH (default 32), APB_DATA_WIDTH (default 32).
// Contents: ADDR_W, DATA_W, STRB_W widths; state_t {IDLE, SETUP, ACCESS};
//           req_fields_t {addr, wdata, strb, prot, write}.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_arb_pkg;

  localparam int ADDR_W = `APB_ADDR_WIDTH;
  localparam int DATA_W = `APB_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [2:0]        prot;
    logic              write;
  } req_fields_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus bundle with master and slave views
// Purpose: groups the APB signals between the arbiter (master) and a completer.
// Signals: psel, penable, pwrite, paddr, pwdata, pstrb, pprot (master drives);
//          prdata, pready, pslverr (slave drives).
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin pick
// Purpose: selects the first valid requester strictly after ptr, wrapping.
// Ports: valid (in, NUM_REQ), ptr (in, IDX_W) last winner,
//        grant (out, one-hot), index (out, IDX_W), any_valid (out).
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any_valid
);

  always_comb begin
    int         cand;
    logic [IDX_W-1:0] cidx;
    logic       found;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    // Offsets 1..NUM_REQ: the previous winner is examined last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && valid[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        index       = cidx;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin sharing of one APB master port
// Purpose: arbitrates NUM_REQ requesters, runs APB SETUP/ACCESS, returns
//          read data and error to the winner as a one-cycle pulse.
// Macro: APB_TIMEOUT_EN enables the ACCESS wait limit (TIMEOUT_CYCLES).
// Ports: clk, rst (async, active-high);
//        req_valid/req_write/req_addr/req_wdata/req_strb/req_prot (in, packed per requester);
//        req_ready (out, one-hot accept), rsp_valid (out, one-hot done),
//        rsp_rdata, rsp_error (out); bus (APB master modport).
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]              req_prot,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_error,
  apb_master_arbiter_if.master              bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t            state_q, state_d;
  req_fields_t       cap_q, cap_d;
  logic [IDX_W-1:0]  gidx_q, ptr_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic              err_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               any_valid;
  logic               grant_en, done, tmo, tmo_hit;

  // Unpacked views of the per-requester fields.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [STRB_WIDTH-1:0] strb_arr  [NUM_REQ];
  logic [2:0]            prot_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[g]  = req_strb[g*STRB_WIDTH +: STRB_WIDTH];
    assign prot_arr[g]  = req_prot[g*3 +: 3];
  end

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .index     (arb_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    cap_d.addr  = ADDR_W'(addr_arr[arb_idx]);
    cap_d.wdata = DATA_W'(wdata_arr[arb_idx]);
    cap_d.strb  = STRB_W'(strb_arr[arb_idx]);
    cap_d.prot  = prot_arr[arb_idx];
    cap_d.write = req_write[arb_idx];
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Cleared while in SETUP so it starts at zero on the first ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !bus.pready) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // True on the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_en = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          done = 1'b1;
          // Back-to-back: re-arbitrate on the completing cycle.
          if (any_valid) begin
            grant_en = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      if (grant_en) begin
        cap_q  <= cap_d;
        gidx_q <= arb_idx;
        ptr_q  <= arb_idx;
      end
      if (done) begin
        rsp_valid_q <= NUM_REQ'(1) << gidx_q;
        rdata_q     <= cap_q.write ? '0 : bus.prdata;
        err_q       <= bus.pslverr;
      end else if (tmo) begin
        rsp_valid_q <= NUM_REQ'(1) << gidx_q;
        err_q       <= 1'b1;
      end
    end
  end

  // IDLE is combinationally transparent to req_valid, so gate the accept
  // pulse while reset is asserted.
  assign req_ready = (grant_en && !rst) ? arb_grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  assign bus.psel    = (state_q != IDLE);
  assign bus.penable = (state_q == ACCESS);
  assign bus.pwrite  = cap_q.write;
  assign bus.paddr   = ADDR_WIDTH'(cap_q.addr);
  assign bus.pwdata  = DATA_WIDTH'(cap_q.wdata);
  assign bus.pstrb   = STRB_WIDTH'(cap_q.strb);
  assign bus.pprot   = cap_q.prot;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N*3-1:0]  req_prot;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;

  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic [SW-1:0] rs [N];
  logic [2:0]    rp [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW]  = ra[g];
    assign req_wdata[g*DW +: DW] = rd[g];
    assign req_strb[g*SW +: SW]  = rs[g];
    assign req_prot[g*3 +: 3]    = rp[g];
  end

  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_arbiter #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected traces for four simultaneous zero-wait requests.
  logic [3:0] t2_rdy  [$] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] t2_rsp  [$] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                              4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
  logic       t2_psel [$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Expected accepts with requesters 1 and 3 held valid.
  logic [3:0] t4_rdy  [$] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [IW-1:0] i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] p);
    ra[i]        = a;
    rd[i]        = d;
    rs[i]        = '1;
    rp[i]        = p;
    req_write[i] = w;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    req_valid   = '0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] prev_rdy;
    for (int j = 0; j < N; j++) begin
      ra[j] = '0; rd[j] = '0; rs[j] = '0; rp[j] = '0;
    end
    req_write   = '0;
    req_valid   = 4'b1111;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;

    // Reset state, with requests pending to show the accept is gated.
    @(posedge clk);
    #2;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_psel", 64'(bus.psel), 64'(0));
    check("rst_penable", 64'(bus.penable), 64'(0));
    check("rst_paddr", 64'(bus.paddr), 64'(0));
    check("rst_rsp_error", 64'(rsp_error), 64'(0));

    // 1: single write from requester 0.
    do_reset();
    cyc();
    set_req(2'd0, 1'b1, AW'(32'h10), DW'(32'hA5A5A5A5), 3'b010);
    bus.pready = 1'b1;
    bus.prdata = DW'(32'hDEADBEEF);
    #1;
    check("t1_ready_c0", 64'(req_ready), 64'(4'b0001));
    check("t1_psel_c0", 64'(bus.psel), 64'(0));
    cyc();
    req_valid = '0;
    #1;
    check("t1_psel_c1", 64'(bus.psel), 64'(1));
    check("t1_penable_c1", 64'(bus.penable), 64'(0));
    check("t1_paddr", 64'(bus.paddr), 64'(32'h10));
    check("t1_pwdata", 64'(bus.pwdata), 64'(DW'(32'hA5A5A5A5)));
    check("t1_pwrite", 64'(bus.pwrite), 64'(1));
    check("t1_pstrb", 64'(bus.pstrb), 64'({SW{1'b1}}));
    check("t1_pprot", 64'(bus.pprot), 64'(3'b010));
    cyc();
    #1;
    check("t1_penable_c2", 64'(bus.penable), 64'(1));
    check("t1_rsp_c2", 64'(rsp_valid), 64'(0));
    cyc();
    #1;
    check("t1_rsp_c3", 64'(rsp_valid), 64'(4'b0001));
    check("t1_err_c3", 64'(rsp_error), 64'(0));
    check("t1_rdata_c3", 64'(rsp_rdata), 64'(0));
    check("t1_psel_c3", 64'(bus.psel), 64'(0));
    cyc();
    #1;
    check("t1_rsp_c4", 64'(rsp_valid), 64'(0));

    // 2: four simultaneous writes, zero wait, back-to-back.
    do_reset();
    bus.pready = 1'b1;
    prev_rdy   = '0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) begin
        for (int j = 0; j < N; j++)
          set_req(IW'(j), 1'b1, AW'(32'h100 + 4 * j), DW'(32'h1000 + j), 3'b000);
      end
      req_valid = req_valid & ~prev_rdy;
      #1;
      check($sformatf("t2_ready_c%0d", c), 64'(req_ready), 64'(t2_rdy[c]));
      check($sformatf("t2_rsp_c%0d", c), 64'(rsp_valid), 64'(t2_rsp[c]));
      check($sformatf("t2_psel_c%0d", c), 64'(bus.psel), 64'(t2_psel[c]));
      if (c % 2 == 1 && c < 8)
        check($sformatf("t2_paddr_c%0d", c), 64'(bus.paddr), 64'(32'h100 + 4 * (c / 2)));
      prev_rdy = req_ready;
    end

    // 3: read from requester 2 with wait states and slave error.
    do_reset();
    cyc();
    set_req(2'd2, 1'b0, AW'(32'h200), DW'(0), 3'b001);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b1;
    bus.prdata  = DW'(32'hBEEF);
    #1;
    check("t3_ready_c0", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = '0;
    #1;
    check("t3_paddr", 64'(bus.paddr), 64'(32'h200));
    check("t3_pwrite", 64'(bus.pwrite), 64'(0));
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      check($sformatf("t3_wait_penable_%0d", k), 64'(bus.penable), 64'(1));
      check($sformatf("t3_wait_rsp_%0d", k), 64'(rsp_valid), 64'(0));
    end
    cyc();
    bus.pready = 1'b1;
    bus.prdata = DW'(32'h1234);
    #1;
    check("t3_rsp_c5", 64'(rsp_valid), 64'(0));
    cyc();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    #1;
    check("t3_rsp_c6", 64'(rsp_valid), 64'(4'b0100));
    check("t3_rdata", 64'(rsp_rdata), 64'(32'h1234));
    check("t3_error", 64'(rsp_error), 64'(1));
    check("t3_psel_c6", 64'(bus.psel), 64'(0));
    cyc();
    #1;
    check("t3_error_clear", 64'(rsp_error), 64'(0));

    // 4: requesters 1 and 3 held continuously.
    do_reset();
    bus.pready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (c == 0) begin
        set_req(2'd1, 1'b0, AW'(32'h310), DW'(0), 3'b000);
        set_req(2'd3, 1'b0, AW'(32'h330), DW'(0), 3'b000);
      end
      #1;
      check($sformatf("t4_ready_c%0d", c), 64'(req_ready), 64'(t4_rdy[c]));
    end
    cyc();
    req_valid = '0;
    repeat (4) cyc();

    // 5: reset asserted mid-ACCESS.
    do_reset();
    cyc();
    set_req(2'd1, 1'b0, AW'(32'h300), DW'(0), 3'b000);
    #1;
    check("t5_ready_c0", 64'(req_ready), 64'(4'b0010));
    cyc();
    req_valid = '0;
    cyc();
    set_req(2'd0, 1'b1, AW'(32'h500), DW'(32'h55), 3'b000);
    set_req(2'd2, 1'b1, AW'(32'h520), DW'(32'h77), 3'b000);
    #1;
    check("t5_penable_access", 64'(bus.penable), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_psel", 64'(bus.psel), 64'(0));
    check("t5_rst_penable", 64'(bus.penable), 64'(0));
    check("t5_rst_ready", 64'(req_ready), 64'(0));
    check("t5_rst_rsp", 64'(rsp_valid), 64'(0));
    check("t5_rst_paddr", 64'(bus.paddr), 64'(0));
    cyc();
    bus.pready = 1'b1;
    #1;
    check("t5_rst_hold_ready", 64'(req_ready), 64'(0));
    check("t5_rst_hold_rsp", 64'(rsp_valid), 64'(0));
    cyc();
    rst = 1'b0;
    #1;
    check("t5_post_ready", 64'(req_ready), 64'(4'b0001));
    check("t5_post_rsp", 64'(rsp_valid), 64'(0));
    cyc();
    req_valid[0] = 1'b0;
    #1;
    check("t5_setup_rsp", 64'(rsp_valid), 64'(0));
    check("t5_setup_paddr", 64'(bus.paddr), 64'(32'h500));
    cyc();
    #1;
    check("t5_next_ready", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = '0;
    #1;
    check("t5_rsp_req0", 64'(rsp_valid), 64'(4'b0001));
    repeat (4) cyc();

`ifdef APB_TIMEOUT_EN
    // 6: completer never responds.
    do_reset();
    cyc();
    set_req(2'd0, 1'b0, AW'(32'h400), DW'(0), 3'b000);
    bus.pready = 1'b0;
    bus.prdata = DW'(32'hFFFF);
    #1;
    check("t6_ready_c0", 64'(req_ready), 64'(4'b0001));
    cyc();
    req_valid = '0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      #1;
      check($sformatf("t6_wait_penable_%0d", k), 64'(bus.penable), 64'(1));
      check($sformatf("t6_wait_rsp_%0d", k), 64'(rsp_valid), 64'(0));
    end
    cyc();
    #1;
    check("t6_abort_psel", 64'(bus.psel), 64'(0));
    check("t6_abort_rsp", 64'(rsp_valid), 64'(4'b0001));
    check("t6_abort_error", 64'(rsp_error), 64'(1));
    check("t6_abort_rdata", 64'(rsp_rdata), 64'(0));
    cyc();
    bus.pready = 1'b1;
    #1;
    check("t6_late_rsp", 64'(rsp_valid), 64'(0));
    cyc();
    #1;
    check("t6_late_rsp2", 64'(rsp_valid), 64'(0));
    check("t6_late_psel", 64'(bus.psel), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
